// File: rtl/dp_cfg_sequencer_pkg.sv
// Shared definitions for the accelerator configuration sequencer: register map,
// result codes, FSM state encodings and the register write order.
package dp_cfg_sequencer_pkg;

  localparam logic [7:0] REG0_OFF = 8'h00;  // control
  localparam logic [7:0] REG1_OFF = 8'h04;  // vector A base
  localparam logic [7:0] REG2_OFF = 8'h08;  // vector B base
  localparam logic [7:0] REG3_OFF = 8'h0C;  // vector length
  localparam logic [7:0] REG4_OFF = 8'h10;  // output address
  localparam logic [7:0] REG5_OFF = 8'h14;  // status

  localparam int NUM_CFG_REGS = 5;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_BRESP    = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ZERO_LEN = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WB, S_START, S_PA, S_PR, S_FIN
  } seq_state_e;

  typedef enum logic [2:0] {
    M_IDLE, M_AW, M_B, M_AR, M_R
  } mst_state_e;

  // Control goes last so the accelerator never sees a new control word with stale operands.
  function automatic logic [7:0] wr_order_off(input logic [2:0] idx);
    case (idx)
      3'd0:    return REG1_OFF;
      3'd1:    return REG2_OFF;
      3'd2:    return REG3_OFF;
      3'd3:    return REG4_OFF;
      default: return REG0_OFF;
    endcase
  endfunction

endpackage

// File: rtl/dp_cfg_sequencer_axil_master.sv
// One AXI-Lite write or read per request. A new request is accepted when idle or
// in the cycle the previous response completes, so back-to-back reads lose no cycle.
module axil_single_beat_master
  import dp_cfg_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_sent,
  output logic                  ack,
  output logic [1:0]            resp,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY
);

  mst_state_e            state_reg, state_next;
  logic                  aw_pend_reg, aw_pend_next;
  logic                  w_pend_reg, w_pend_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= M_IDLE;
      aw_pend_reg <= 1'b0;
      w_pend_reg  <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      aw_pend_reg <= aw_pend_next;
      w_pend_reg  <= w_pend_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_pend_next = aw_pend_reg;
    w_pend_next  = w_pend_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    req_sent     = 1'b0;
    ack          = 1'b0;
    case (state_reg)
      M_AW: begin
        // Each channel retires on its own handshake; the response phase waits for both.
        if (AWREADY) aw_pend_next = 1'b0;
        if (WREADY)  w_pend_next  = 1'b0;
        if ((!aw_pend_reg || AWREADY) && (!w_pend_reg || WREADY)) begin
          req_sent   = 1'b1;
          state_next = M_B;
        end
      end
      M_B: if (BVALID) begin
        ack        = 1'b1;
        state_next = M_IDLE;
      end
      M_AR: if (ARREADY) begin
        req_sent   = 1'b1;
        state_next = M_R;
      end
      M_R: if (RVALID) begin
        ack        = 1'b1;
        state_next = M_IDLE;
      end
      default: state_next = M_IDLE;
    endcase
    if ((state_reg == M_IDLE || ack) && req) begin
      addr_next = req_addr;
      if (req_we) begin
        data_next    = req_wdata;
        aw_pend_next = 1'b1;
        w_pend_next  = 1'b1;
        state_next   = M_AW;
      end else begin
        state_next = M_AR;
      end
    end
  end

  assign AWADDR  = addr_reg;
  assign AWVALID = aw_pend_reg;
  assign WDATA   = data_reg;
  assign WVALID  = w_pend_reg;
  assign BREADY  = (state_reg == M_B);
  assign ARADDR  = addr_reg;
  assign ARVALID = (state_reg == M_AR);
  assign RREADY  = (state_reg == M_R);
  assign resp    = BRESP;
  assign rdata   = RDATA;

endmodule

// File: rtl/dp_cfg_sequencer.sv
// Programs the accelerator register file over AXI-Lite, kicks it off, then polls
// the status register until the done bit or the poll limit, reporting the outcome.
module dp_cfg_sequencer
  import dp_cfg_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_LIMIT = 1024,
  parameter int DONE_BIT   = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] cfg_ctrl,
  input  logic [DATA_WIDTH-1:0] cfg_a_base,
  input  logic [DATA_WIDTH-1:0] cfg_b_base,
  input  logic [DATA_WIDTH-1:0] cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_out_addr,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic                  start_signal,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [DATA_WIDTH-1:0] status_out
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  seq_state_e            state_reg, state_next;
  logic [2:0]            idx_reg, idx_next;
  logic [PCW-1:0]        poll_reg, poll_next, poll_inc;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  err_code_e             code_reg, code_next;
  logic [DATA_WIDTH-1:0] status_reg, status_next;

  logic                  req, req_we, req_sent, ack;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata, rdata;
  logic [1:0]            resp;
  logic [7:0]            wr_off;
  logic                  cfg_capture;

  // cfg_in/cfg_q are indexed by register number (REGn).
  logic [DATA_WIDTH-1:0] cfg_in [NUM_CFG_REGS];
  logic [DATA_WIDTH-1:0] cfg_q  [NUM_CFG_REGS];

  assign cfg_in[0]   = cfg_ctrl;
  assign cfg_in[1]   = cfg_a_base;
  assign cfg_in[2]   = cfg_b_base;
  assign cfg_in[3]   = cfg_len;
  assign cfg_in[4]   = cfg_out_addr;
  assign cfg_capture = (state_reg == S_IDLE) && go;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CFG_REGS; gi++) begin : g_cfg
      logic [DATA_WIDTH-1:0] val_reg;
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)         val_reg <= '0;
        else if (cfg_capture) val_reg <= cfg_in[gi];
      end
      assign cfg_q[gi] = val_reg;
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      poll_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      code_reg   <= ERR_OK;
      status_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      poll_reg   <= poll_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      code_reg   <= code_next;
      status_reg <= status_next;
    end
  end

  assign wr_off   = wr_order_off(idx_reg);
  assign poll_inc = poll_reg + PCW'(1);

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    poll_next   = poll_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    err_next    = err_reg;
    code_next   = code_reg;
    status_next = status_reg;
    req         = 1'b0;
    req_we      = 1'b0;
    req_addr    = ADDR_WIDTH'(wr_off);
    req_wdata   = cfg_q[wr_off[4:2]];
    case (state_reg)
      S_IDLE: if (go) begin
        busy_next   = 1'b1;
        status_next = '0;
        err_next    = 1'b0;
        code_next   = ERR_OK;
        idx_next    = '0;
        if (cfg_len == '0) begin
          err_next   = 1'b1;
          code_next  = ERR_ZERO_LEN;
          state_next = S_FIN;
        end else begin
          state_next = S_WR;
        end
      end
      S_WR: begin
        req    = 1'b1;
        req_we = 1'b1;
        if (req_sent) state_next = S_WB;
      end
      S_WB: if (ack) begin
        if (resp != 2'b00) begin
          err_next   = 1'b1;
          code_next  = ERR_BRESP;
          state_next = S_FIN;
        end else if (idx_reg == 3'(NUM_CFG_REGS - 1)) begin
          state_next = S_START;
        end else begin
          idx_next   = idx_reg + 3'd1;
          state_next = S_WR;
        end
      end
      S_START: begin
        // The first status read is issued alongside the start pulse.
        poll_next  = '0;
        req        = 1'b1;
        req_addr   = ADDR_WIDTH'(REG5_OFF);
        state_next = S_PA;
      end
      S_PA: if (req_sent) state_next = S_PR;
      S_PR: if (ack) begin
        status_next = rdata;
        poll_next   = poll_inc;
        if (rdata[DONE_BIT]) begin
          state_next = S_FIN;
        end else if (poll_inc == PCW'(POLL_LIMIT)) begin
          err_next   = 1'b1;
          code_next  = ERR_TIMEOUT;
          state_next = S_FIN;
        end else begin
          req        = 1'b1;
          req_addr   = ADDR_WIDTH'(REG5_OFF);
          state_next = S_PA;
        end
      end
      S_FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  axil_single_beat_master #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_master (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_sent (req_sent),
    .ack      (ack),
    .resp     (resp),
    .rdata    (rdata),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .ARADDR   (ARADDR),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RDATA    (RDATA),
    .RVALID   (RVALID),
    .RREADY   (RREADY)
  );

  assign start_signal = (state_reg == S_START);
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign err_code     = code_reg;
  assign status_out   = status_reg;

endmodule

// File: tb/tb_dp_cfg_sequencer.sv
// Directed bench for dp_cfg_sequencer with a small AXI-Lite register slave model
// whose AWREADY delay, BRESP injection and done-bit timing are set per step.
module tb_dp_cfg_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        go = 1'b0;
  logic [31:0] cfg_ctrl = '0, cfg_a_base = '0, cfg_b_base = '0, cfg_len = '0, cfg_out_addr = '0;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, status_out;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, err_code;
  logic        start_signal, busy, done, err;

  // Slave knobs and bookkeeping
  int          aw_delay = 0;
  bit          inject_bresp = 1'b0;
  int          rd_done_at = 0;
  int          aw_cnt = 0;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic [31:0] wr_addr_log [64];
  logic [31:0] wr_data_log [64];
  int          wr_n = 0, ar_total = 0;
  int          aw_total = 0, start_total = 0, done_total = 0, valid_cycles = 0;
  int          passed = 0, failed = 0, total = 0;
  logic [31:0] exp_addr [5];
  logic [31:0] exp_data [5];

  always #5 ACLK = ~ACLK;

  dp_cfg_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .POLL_LIMIT(4), .DONE_BIT(0)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .go(go),
    .cfg_ctrl(cfg_ctrl), .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base),
    .cfg_len(cfg_len), .cfg_out_addr(cfg_out_addr),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .start_signal(start_signal), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .status_out(status_out)
  );

  assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
  assign WREADY  = 1'b1;
  assign ARREADY = 1'b1;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      BVALID <= 1'b0; RVALID <= 1'b0; BRESP <= 2'b00; RDATA <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
    end else begin
      if (AWVALID && !AWREADY) aw_cnt <= aw_cnt + 1;
      else                     aw_cnt <= 0;
      if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_addr_q <= AWADDR; end
      if (WVALID && WREADY)   begin w_got <= 1'b1;  w_data_q <= WDATA;   end
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY)) && !BVALID) begin
        BVALID <= 1'b1;
        BRESP  <= (inject_bresp && ((aw_got ? aw_addr_q : AWADDR) == 32'h0C)) ? 2'b10 : 2'b00;
      end
      if (BVALID && BREADY) begin
        BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        wr_addr_log[wr_n] <= aw_addr_q;
        wr_data_log[wr_n] <= w_data_q;
        wr_n <= wr_n + 1;
      end
      if (ARVALID && ARREADY) begin
        RVALID   <= 1'b1;
        RDATA    <= (ar_total + 1 == rd_done_at) ? 32'h1 : 32'h0;
        ar_total <= ar_total + 1;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  always @(posedge ACLK) begin
    if (ARESETN) begin
      if (AWVALID && AWREADY)           aw_total     <= aw_total + 1;
      if (start_signal)                 start_total  <= start_total + 1;
      if (done)                         done_total   <= done_total + 1;
      if (AWVALID || WVALID || ARVALID) valid_cycles <= valid_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge ACLK);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < budget) begin
      @(negedge ACLK);
      lat++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic set_cfg(input logic [31:0] len);
    cfg_ctrl = 32'hC000_0001; cfg_a_base = 32'h0000_1000; cfg_b_base = 32'h0000_2000;
    cfg_len  = len;           cfg_out_addr = 32'h0000_3000;
  endtask

  initial begin
    int lat, n, b_aw, b_ar, b_st, b_wr, b_done, b_vc;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_ctrl", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, start_signal, busy, done, err, err_code}), 32'd0);
    check("rst_status", status_out, 32'd0);
    check("rst_addr_data", AWADDR | ARADDR | WDATA, 32'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Step 1: zero-wait slave, length 3, status reads 0,0,1
    set_cfg(32'd3);
    exp_addr = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h00};
    exp_data = '{32'h1000, 32'h2000, 32'h3, 32'h3000, 32'hC000_0001};
    rd_done_at = ar_total + 3;
    b_aw = aw_total; b_ar = ar_total; b_st = start_total; b_wr = wr_n;
    pulse_go();
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1", 200, lat);
    check("t1_latency", lat, 32'd23);
    check("t1_err", {29'd0, err, err_code}, 32'd0);
    check("t1_status", status_out, 32'h1);
    check("t1_aw_count", aw_total - b_aw, 32'd5);
    check("t1_start_count", start_total - b_st, 32'd1);
    check("t1_ar_count", ar_total - b_ar, 32'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1_wr%0d_addr", i), wr_addr_log[b_wr + i], exp_addr[i]);
      check($sformatf("t1_wr%0d_data", i), wr_data_log[b_wr + i], exp_data[i]);
    end
    @(negedge ACLK);
    check("t1_busy_low", {31'd0, busy}, 32'd0);

    // Step 2: AWREADY held off 3 cycles, WREADY immediate
    aw_delay = 3;
    rd_done_at = ar_total + 1;
    pulse_go();
    @(negedge ACLK);
    check("t2_valids_up", {30'd0, AWVALID, WVALID}, 32'b11);
    check("t2_awaddr_c2", AWADDR, 32'h04);
    @(negedge ACLK);
    check("t2_w_drops", {29'd0, AWVALID, WVALID, BREADY}, 32'b100);
    @(negedge ACLK);
    check("t2_aw_hold", {30'd0, AWVALID, BREADY}, 32'b10);
    check("t2_awaddr_c4", AWADDR, 32'h04);
    @(negedge ACLK);
    check("t2_aw_ready", {29'd0, AWVALID, AWREADY, BREADY}, 32'b110);
    check("t2_awaddr_c5", AWADDR, 32'h04);
    @(negedge ACLK);
    check("t2_wb_entered", {30'd0, AWVALID, BREADY}, 32'b01);
    wait_done("t2", 300, lat);
    check("t2_err", {29'd0, err, err_code}, 32'd0);
    aw_delay = 0;
    @(negedge ACLK);

    // Step 3: BRESP error on the REG3 write
    inject_bresp = 1'b1;
    b_aw = aw_total; b_ar = ar_total; b_st = start_total;
    pulse_go();
    wait_done("t3", 200, lat);
    check("t3_err", {29'd0, err, err_code}, 32'b101);
    check("t3_aw_count", aw_total - b_aw, 32'd3);
    check("t3_no_start", start_total - b_st, 32'd0);
    check("t3_no_reads", ar_total - b_ar, 32'd0);
    inject_bresp = 1'b0;
    @(negedge ACLK);

    // Step 4: status never done, poll limit 4
    rd_done_at = 0;
    b_ar = ar_total; b_st = start_total;
    pulse_go();
    wait_done("t4", 200, lat);
    check("t4_err", {29'd0, err, err_code}, 32'b110);
    check("t4_ar_count", ar_total - b_ar, 32'd4);
    check("t4_start_count", start_total - b_st, 32'd1);
    check("t4_status", status_out, 32'd0);
    @(negedge ACLK);

    // Step 5: zero length rejected without bus traffic
    set_cfg(32'd0);
    b_vc = valid_cycles;
    pulse_go();
    check("t5_not_yet", {31'd0, done}, 32'd0);
    wait_done("t5", 20, lat);
    check("t5_latency", lat, 32'd1);
    check("t5_err", {29'd0, err, err_code}, 32'b111);
    check("t5_busy_low", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge ACLK);
    check("t5_no_valid", valid_cycles - b_vc, 32'd0);

    // Step 6: reset while a status read response is pending, then a clean rerun
    set_cfg(32'd3);
    rd_done_at = 0;
    pulse_go();
    n = 0;
    while (RREADY !== 1'b1 && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    check("t6_in_pr", {31'd0, RREADY}, 32'd1);
    check("t6_rvalid_pending", {31'd0, RVALID}, 32'd1);
    b_done = done_total;
    #2 ARESETN = 1'b0;
    #1;
    check("t6_rst_ctrl", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, start_signal, busy, done, err, err_code}), 32'd0);
    check("t6_rst_status", status_out, 32'd0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    check("t6_no_done", done_total - b_done, 32'd0);
    rd_done_at = ar_total + 2;
    b_aw = aw_total; b_st = start_total; b_done = done_total; b_wr = wr_n;
    pulse_go();
    repeat (3) @(negedge ACLK);
    pulse_go();
    wait_done("t6", 200, lat);
    check("t6_err", {29'd0, err, err_code}, 32'd0);
    check("t6_status", status_out, 32'h1);
    check("t6_first_wr_addr", wr_addr_log[b_wr], 32'h04);
    repeat (40) @(negedge ACLK);
    check("t6_aw_count", aw_total - b_aw, 32'd5);
    check("t6_start_count", start_total - b_st, 32'd1);
    check("t6_one_done", done_total - b_done, 32'd1);
    check("t6_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
